// File: rtl/glip_uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud divisor / counter-width helpers.
package glip_uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_e;

  function automatic int unsigned uart_divisor(input int unsigned freq, input int unsigned baud);
    return freq / baud;
  endfunction

  function automatic int unsigned uart_cnt_width(input int unsigned divisor);
    return (divisor < 2) ? 1 : $clog2(divisor);
  endfunction

endpackage

// File: rtl/glip_uart_receive_if.sv
// Byte stream handshake (data/valid/ready) between the receive buffer and its consumer.
interface glip_uart_receive_if;
  import glip_uart_pkg::*;

  logic [UART_DATA_W-1:0] data;
  logic                   valid;
  logic                   ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/glip_uart_rx_buffer.sv
// Two-entry FIFO between the receive FSM and the byte consumer.
module glip_uart_rx_buffer
  import glip_uart_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  glip_uart_receive_if.master    out,
  output logic                   full,
  output logic                   empty
);

  logic [UART_DATA_W-1:0] mem [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             count;
  logic                   pop;
  logic                   wr;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign pop      = out.valid && out.ready;
  // A pop in the same cycle frees the slot, so a full buffer still takes the push.
  assign in_ready = !full || pop;
  assign wr       = in_valid && in_ready;

  assign out.valid = !empty;
  assign out.data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '{default: '0};
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({wr, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/glip_uart_receive.sv
// UART receiver: synchronizes rx, decodes 8N1 frames and buffers bytes in a 2-entry FIFO.
module glip_uart_receive
  import glip_uart_pkg::*;
#(
  parameter logic [31:0] FREQ = 32'd16,
  parameter logic [31:0] BAUD = 32'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       error_framing,
  output logic       error_overrun,
  output logic       error
);

  localparam int unsigned DIVISOR = uart_divisor(FREQ, BAUD);
  localparam int unsigned CW      = uart_cnt_width(DIVISOR);
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIVISOR / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIVISOR - 1);

  generate
    if (DIVISOR < 4) begin : g_divisor_check
      $fatal(1, "glip_uart_receive: FREQ/BAUD must be at least 4");
    end
  endgenerate

  logic sync_q;
  logic rxs;

  uart_state_e            state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   push;
  logic                   framing_evt;

  logic buf_in_ready;
  logic buf_full;
  logic buf_empty;
  logic unused_buf_flags;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      sync_q <= rx;
      rxs    <= sync_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    framing_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rxs) begin
          state_d = DATA;
          cnt_d   = FULL_LOAD;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d[idx_q] = rxs;
          cnt_d          = FULL_LOAD;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rxs) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          framing_evt = 1'b1;
          state_d     = BREAK;
        end
      end
      BREAK: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  glip_uart_receive_if bus ();

  glip_uart_rx_buffer u_buffer (
    .clk      (clk),
    .rst      (rst),
    .in_data  (shift_q),
    .in_valid (push),
    .in_ready (buf_in_ready),
    .out      (bus),
    .full     (buf_full),
    .empty    (buf_empty)
  );

  assign out_data         = bus.data;
  assign out_valid        = bus.valid;
  assign bus.ready        = out_ready;
  assign unused_buf_flags = buf_full ^ buf_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      error_framing <= 1'b0;
      error_overrun <= 1'b0;
    end else begin
      if (framing_evt) error_framing <= 1'b1;
      if (push && !buf_in_ready) error_overrun <= 1'b1;
    end
  end

  assign error = error_framing || error_overrun;

endmodule

// File: tb/tb_glip_uart_receive.sv
// Directed bench for glip_uart_receive at FREQ=16, BAUD=1 (16 clocks per bit).
module tb_glip_uart_receive;
  import glip_uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b1;
  logic error_framing, error_overrun, error;

  glip_uart_receive_if obs ();

  glip_uart_receive #(.FREQ(32'd16), .BAUD(32'd1)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .out_data      (obs.data),
    .out_valid     (obs.valid),
    .out_ready     (obs.ready),
    .error_framing (error_framing),
    .error_overrun (error_overrun),
    .error         (error)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [7:0]  got[$];
  int unsigned valid_cycles = 0;

  always @(negedge clk) begin
    if (obs.valid === 1'b1) valid_cycles++;
    if (obs.valid === 1'b1 && obs.ready === 1'b1) got.push_back(obs.data);
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(16);
    end
    rx = stop;
    tick(16);
  endtask

  task automatic clear_obs();
    got.delete();
    valid_cycles = 0;
  endtask

  function automatic logic [31:0] got_at(input int unsigned i);
    if (i < got.size()) return {24'd0, got[i]};
    return 32'hxxxx_xxxx;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    rx  = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(3);
  endtask

  initial begin
    obs.ready = 1'b0;
    tick(3);
    check("rst_valid", {31'd0, obs.valid}, 32'd0);
    check("rst_data", {24'd0, obs.data}, 32'h00);
    check("rst_framing", {31'd0, error_framing}, 32'd0);
    check("rst_overrun", {31'd0, error_overrun}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b1;
    tick(3);

    // Single frame 0xA5, consumer always ready
    obs.ready = 1'b1;
    clear_obs();
    send_frame(8'hA5, 1'b1);
    tick(30);
    check("a5_count", got.size(), 32'd1);
    check("a5_data", got_at(0), 32'hA5);
    check("a5_valid_cycles", valid_cycles, 32'd1);
    check("a5_error", {31'd0, error}, 32'd0);

    // Glitch: 4 low cycles
    clear_obs();
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    check("glitch_valid_cycles", valid_cycles, 32'd0);
    check("glitch_state", 32'(dut.state_q), 32'(IDLE));

    // Framing error, break, recovery
    clear_obs();
    send_frame(8'h3C, 1'b0);
    tick(40);
    check("break_state", 32'(dut.state_q), 32'(BREAK));
    rx = 1'b1;
    tick(20);
    check("frame_err_nobyte", got.size(), 32'd0);
    check("frame_err_flag", {31'd0, error_framing}, 32'd1);
    check("frame_err_any", {31'd0, error}, 32'd1);
    send_frame(8'h11, 1'b1);
    tick(30);
    check("after_break_count", got.size(), 32'd1);
    check("after_break_data", got_at(0), 32'h11);
    check("frame_err_sticky", {31'd0, error_framing}, 32'd1);
    check("frame_err_no_ovr", {31'd0, error_overrun}, 32'd0);

    // Overrun with consumer stalled
    do_reset();
    check("clr_framing", {31'd0, error_framing}, 32'd0);
    obs.ready = 1'b0;
    clear_obs();
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    tick(30);
    check("ovr_flag", {31'd0, error_overrun}, 32'd1);
    check("ovr_no_framing", {31'd0, error_framing}, 32'd0);
    check("ovr_hold_valid", {31'd0, obs.valid}, 32'd1);
    check("ovr_hold_data", {24'd0, obs.data}, 32'h01);
    obs.ready = 1'b1;
    tick(10);
    check("ovr_count", got.size(), 32'd2);
    check("ovr_first", got_at(0), 32'h01);
    check("ovr_second", got_at(1), 32'h02);
    check("ovr_empty", {31'd0, obs.valid}, 32'd0);

    // Back-to-back frames
    do_reset();
    clear_obs();
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    rx = 1'b1;
    tick(30);
    check("b2b_count", got.size(), 32'd2);
    check("b2b_first", got_at(0), 32'h55);
    check("b2b_second", got_at(1), 32'hAA);
    check("b2b_error", {31'd0, error}, 32'd0);

    // Reset in the middle of DATA for 0xFF
    clear_obs();
    rx = 1'b0;
    tick(16);
    rx = 1'b1;
    tick(40);
    check("mid_state_data", 32'(dut.state_q), 32'(DATA));
    rst = 1'b0;
    tick(5);
    check("mid_rst_valid", {31'd0, obs.valid}, 32'd0);
    check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b1;
    tick(200);
    check("mid_nobyte", got.size(), 32'd0);
    check("mid_flags", {30'd0, error_framing, error_overrun}, 32'd0);
    send_frame(8'h42, 1'b1);
    tick(30);
    check("post_rst_count", got.size(), 32'd1);
    check("post_rst_data", got_at(0), 32'h42);
    check("post_rst_error", {31'd0, error}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/glip_uart_receive.md
GLIP_UART_RECEIVE -- requirements
Module: glip_uart_receive

Interface
REQ-001 SHALL have parameter FREQ, default 32'd16, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 32'd1, meaning line bit rate; DIVISOR = FREQ/BAUD clocks per bit, with DIVISOR >= 4 enforced at elaboration.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port rx, input, 1, meaning the asynchronous UART serial line, idle high.
REQ-006 SHALL have port out_data, output, 8, meaning the received byte, which feeds the control layer's ingress_in_data.
REQ-007 SHALL have port out_valid, output, 1, meaning out_data holds a byte.
REQ-008 SHALL have port out_ready, input, 1, meaning the consumer accepts the byte in the current cycle.
REQ-009 SHALL have port error_framing, output, 1, meaning a sticky flag for a bad stop bit.
REQ-010 SHALL have port error_overrun, output, 1, meaning a sticky flag for a byte dropped because the buffer was full.
REQ-011 SHALL have port error, output, 1, meaning error_framing OR error_overrun.

Function
REQ-012 SHALL pass rx through a two-flop synchronizer set to 1 at reset; the FSM uses only the synchronized value rxs.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP and BREAK.
REQ-014 IDLE: on rxs==0, go to START and load the bit counter with DIVISOR/2-1.
REQ-015 START: when the counter reaches 0, go to DATA with counter DIVISOR-1 and bit index 0 if rxs==0; otherwise treat the event as a glitch and return to IDLE.
REQ-016 DATA: at each counter expiry, sample rxs into shift register bit [index] (LSB first) and reload DIVISOR-1; after index 7, go to STOP.
REQ-017 STOP: at counter expiry with rxs==1, push the byte to the buffer and go to IDLE.
REQ-018 STOP: at counter expiry with rxs==0, discard the byte, set error_framing and go to BREAK.
REQ-019 BREAK: stay until rxs==1, then go to IDLE; no start bit is detected while in BREAK.
REQ-020 SHALL buffer received bytes in a 2-entry FIFO; out_valid equals FIFO non-empty and out_data equals the FIFO head.
REQ-021 A transfer occurs when out_valid && out_ready; out_data/out_valid SHALL stay stable while out_valid && !out_ready.
REQ-022 A pushed byte SHALL appear at out_valid in the cycle after the stop-bit sample cycle if the FIFO was empty.
REQ-023 On a push into a full FIFO, the byte SHALL be dropped, error_overrun set, and FIFO contents left unchanged.
REQ-024 A simultaneous push and pop on a full FIFO SHALL accept the push with no overrun.
REQ-025 A simultaneous push and pop on a 1-entry FIFO SHALL leave the count at 1.
REQ-026 FIFO pointers SHALL wrap modulo 2; the count width is 2 bits and never exceeds 2.
REQ-027 The bit counter width SHALL be clog2(DIVISOR) and it SHALL count down only.
REQ-028 The FSM SHALL accept a new start bit in the cycle after returning to IDLE, so back-to-back frames are received without loss.

Reset
REQ-029 While rst==0: state IDLE, counters 0, synchronizer flops 1, FIFO empty, out_valid 0, out_data 8'h00, error flags 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately and discard the partial byte.
REQ-031 Error flags SHALL be cleared only by reset.
REQ-032 Reset deassertion SHALL be synchronized by the integrating level; the first active cycle SHALL start in IDLE.

Structure
REQ-033 The FSM state encoding and the DIVISOR/counter-width calculation SHALL live in the shared package glip_uart_pkg, reused by the transmitter.
REQ-034 The 2-entry FIFO SHALL be the single sub-module glip_uart_rx_buffer (valid/ready in and out, full/empty outputs); everything else stays flat.

Verification
REQ-035 FREQ=16, BAUD=1, frame 0xA5 with out_ready=1 -> out_data=8'hA5 with out_valid for exactly 1 cycle; no error flags set.
REQ-036 rx low for 4 cycles, then high -> glitch rejected, no out_valid, state returns to IDLE.
REQ-037 Frame 0x3C with stop bit 0 -> no byte delivered, error_framing=1; rx held low 40 cycles, then frame 0x11 -> 0x11 delivered.
REQ-038 out_ready=0, three frames 0x01, 0x02, 0x03 -> error_overrun=1; after out_ready=1, pops deliver 0x01 then 0x02, and 0x03 is never delivered.
REQ-039 Two back-to-back frames 0x55, 0xAA with out_ready=1 -> both delivered in order, with no errors.
REQ-040 rst pulled low in the middle of DATA for frame 0xFF -> no output; all flags 0; a following frame 0x42 is received correctly.
